out_port_buffer: RTL and testbench

Output-port stage that sits directly downstream of the 4-input round-robin arbiter in each router port. It consumes the arbiter's one-hot `grant` / `grant_v_o`, selects the granted input's flit, stores it in a small FIFO, and drains the FIFO to the outgoing link with a valid/ready handshake. Its `buffer_full_o` drives the arbiter's `buffer_full_i`, closing the back-pressure loop.

---
 rtl/knock_pkg.sv | 25 ++
 rtl/out_port_buffer_if.sv | 23 ++
 rtl/flit_fifo.sv | 65 ++++++
 rtl/out_port_buffer.sv | 62 ++++++
 tb/tb_out_port_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/knock_pkg.sv
// Shared router types and helpers for the output-port stage.
// Provides the grant encoder and the one-hot test used by out_port_buffer.
package knock_pkg;

    localparam int NUM_PORTS = 4;
    localparam int FLIT_W    = 32;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [1:0]        port_idx_t;

    // Lowest set bit wins, so a malformed grant still selects a single port.
    function automatic port_idx_t lowest_set(input logic [NUM_PORTS-1:0] g);
        port_idx_t idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (g[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_PORTS-1:0] g);
        return (g != '0) && ((g & (g - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/out_port_buffer_if.sv
// Arbiter-side and link-side signals of the output-port buffer.
// slave = buffer, master = arbiter plus downstream link.
interface out_port_buffer_if #(
    parameter int FLIT_W = knock_pkg::FLIT_W
);
    logic [knock_pkg::NUM_PORTS-1:0]             grant_i;
    logic                                        grant_v_i;
    logic [knock_pkg::NUM_PORTS-1:0][FLIT_W-1:0] flit_i;
    logic                                        buffer_full_o;
    logic [FLIT_W-1:0]                           data_o;
    logic                                        valid_o;
    logic                                        ready_i;

    modport slave (
        input  grant_i, grant_v_i, flit_i, ready_i,
        output buffer_full_o, data_o, valid_o
    );

    modport master (
        output grant_i, grant_v_i, flit_i, ready_i,
        input  buffer_full_o, data_o, valid_o
    );
endinterface

// File: rtl/flit_fifo.sv
// Show-ahead FIFO: storage, wrap-around pointers and occupancy count.
// Push while full and pop while empty are ignored.
module flit_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count only, so no input reaches them.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/out_port_buffer.sv
// Output-port stage: grant-selected flit into a FIFO, drained over valid/ready.
// OUT_PORT_BUF_CHECK_EN enables a sticky protocol-error flag and drops non-one-hot grants.
module out_port_buffer #(
    parameter int FLIT_W = knock_pkg::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    out_port_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    error_o
);
    import knock_pkg::*;

    port_idx_t         sel_idx;
    logic [FLIT_W-1:0] wr_flit;
    logic              grant_ok;
    logic              wr_en;
    logic              empty;

    assign sel_idx = lowest_set(bus.grant_i);
    assign wr_flit = bus.flit_i[sel_idx];
    assign wr_en   = bus.grant_v_i & grant_ok;
    assign bus.valid_o = ~empty;

`ifdef OUT_PORT_BUF_CHECK_EN
    logic error_q, error_d;

    assign grant_ok = is_onehot(bus.grant_i);

    always_comb begin
        error_d = error_q;
        if (bus.grant_v_i && (!grant_ok || bus.buffer_full_o)) error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) error_q <= 1'b0;
        else      error_q <= error_d;
    end

    assign error_o = error_q;
`else
    assign grant_ok = 1'b1;
    assign error_o  = 1'b0;
`endif

    flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en),
        .pop_i   (bus.ready_i),
        .wdata_i (wr_flit),
        .rdata_o (bus.data_o),
        .full_o  (bus.buffer_full_o),
        .empty_o (empty),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_out_port_buffer.sv
// Scoreboard bench for out_port_buffer: stimulus queues expected flits,
// a negedge monitor pops and compares every accepted output.
module tb_out_port_buffer;
    import knock_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef OUT_PORT_BUF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] count_o;
    logic          error_o;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   exp_q [$];

    out_port_buffer_if #(.FLIT_W(32)) bus ();

    out_port_buffer #(.FLIT_W(32), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count_o (count_o),
        .error_o (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a transfer completes at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst && bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h expected none", bus.data_o);
            end else begin
                e = exp_q.pop_front();
                $display("xfer data=%h exp=%h", bus.data_o, e);
                check("data_o", {32'h0, bus.data_o}, {32'h0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.grant_v_i = 1'b0;
        bus.grant_i   = '0;
    endtask

    task automatic drive_write(input int p, input logic [31:0] val, input bit push);
        for (int k = 0; k < NUM_PORTS; k++) bus.flit_i[k] = 32'hBAD0_0000 + 32'(k);
        bus.grant_i   = 4'(1 << p);
        bus.grant_v_i = 1'b1;
        bus.flit_i[p] = val;
        if (push) exp_q.push_back(val);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        idle();
        bus.ready_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.grant_i   = '0;
        bus.grant_v_i = 1'b0;
        bus.ready_i   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) bus.flit_i[k] = '0;

        // Reset state
        #1;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_full", 64'(bus.buffer_full_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();

        // Single flit, 1-cycle latency
        bus.ready_i = 1'b1;
        drive_write(2, 32'hA5A5_0002, 1'b1);
        check("t1_valid_before", 64'(bus.valid_o), 64'd0);
        tick();
        idle();
        check("t1_valid", 64'(bus.valid_o), 64'd1);
        check("t1_data", 64'(bus.data_o), 64'hA5A5_0002);
        check("t1_count", 64'(count_o), 64'd1);
        tick();
        check("t1_valid_after", 64'(bus.valid_o), 64'd0);

        // Fill to full from all four ports, then drain
        bus.ready_i = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drive_write(p, 32'(p + 1), 1'b1);
            tick();
            check("t2_count_fill", 64'(count_o), 64'(p + 1));
            check("t2_full_fill", 64'(bus.buffer_full_o), (p == 3) ? 64'd1 : 64'd0);
        end
        idle();
        bus.ready_i = 1'b1;
        tick();
        check("t2_full_drop", 64'(bus.buffer_full_o), 64'd0);
        check("t2_count_pop", 64'(count_o), 64'd3);
        repeat (3) tick();
        check("t2_count_empty", 64'(count_o), 64'd0);

        // Overflow attempt while popping from full
        bus.ready_i = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drive_write(p, 32'h11 + 32'(p), 1'b1);
            tick();
        end
        check("t3_full", 64'(bus.buffer_full_o), 64'd1);
        drive_write(0, 32'h99, 1'b0);
        bus.ready_i = 1'b1;
        tick();
        idle();
        check("t3_count", 64'(count_o), 64'd3);
        check("t3_error", 64'(error_o), 64'(CHK));
        repeat (3) tick();
        check("t3_count_empty", 64'(count_o), 64'd0);
        do_reset();
        check("t3_error_cleared", 64'(error_o), 64'd0);

        // Steady state at count 2 with simultaneous push/pop across pointer wrap
        bus.ready_i = 1'b0;
        drive_write(0, 32'h20, 1'b1);
        tick();
        drive_write(1, 32'h21, 1'b1);
        tick();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_write(k % 4, 32'h22 + 32'(k), 1'b1);
            tick();
            check("t4_count_steady", 64'(count_o), 64'd2);
        end
        idle();
        repeat (2) tick();
        check("t4_count_empty", 64'(count_o), 64'd0);

        // Non-one-hot grant
        bus.ready_i = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) bus.flit_i[k] = 32'hBAD0_0000 + 32'(k);
        bus.grant_i   = 4'b0011;
        bus.grant_v_i = 1'b1;
        bus.flit_i[0] = 32'h50;
        bus.flit_i[1] = 32'h51;
        if (!CHK) exp_q.push_back(32'h50);
        tick();
        idle();
        check("t5_count", 64'(count_o), CHK ? 64'd0 : 64'd1);
        check("t5_error", 64'(error_o), 64'(CHK));
        bus.ready_i = 1'b1;
        tick();
        check("t5_count_empty", 64'(count_o), 64'd0);
        check("t5_error_sticky", 64'(error_o), 64'(CHK));
        do_reset();

        // Asynchronous reset mid-cycle discards stored flits
        bus.ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_write(k, 32'h60 + 32'(k), 1'b1);
            tick();
        end
        idle();
        check("t6_count_pre", 64'(count_o), 64'd3);
        #3;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_valid_async", 64'(bus.valid_o), 64'd0);
        check("t6_count_async", 64'(count_o), 64'd0);
        check("t6_full_async", 64'(bus.buffer_full_o), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        check("t6_valid_after", 64'(bus.valid_o), 64'd0);
        check("t6_count_after", 64'(count_o), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
